// File: rtl/branch_predictor_table_if.sv
// Fetch/resolve port bundle for the branch history table.
// master: fetch/resolve logic driving indices and outcomes.
// slave:  the table, returning the prediction.
interface branch_predictor_table_if #(
    parameter int ADDR_W = 5
);
    logic              brTaken_i;
    logic [ADDR_W-1:0] branchAddrWrite_i;
    logic [ADDR_W-1:0] branchAddrRead_i;
    logic              anUpdate_i;
    logic              whatToDoBranch_o;

    modport master (
        output brTaken_i,
        output branchAddrWrite_i,
        output branchAddrRead_i,
        output anUpdate_i,
        input  whatToDoBranch_o
    );

    modport slave (
        input  brTaken_i,
        input  branchAddrWrite_i,
        input  branchAddrRead_i,
        input  anUpdate_i,
        output whatToDoBranch_o
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Branch history table: 32 two-bit saturating counters, combinational
// read at one index, clocked update at another.
// Optional macro BRPRED_WRITE_BYPASS_EN: a read of the index being updated
// returns the post-update prediction in the same cycle.

// One 2-bit saturating counter entry.
module branchPredictionSM (
    input  logic clk_i,
    input  logic reset_i,
    input  logic update_i,
    input  logic taken_i,
    output logic prediction_o
);
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } counterState_t;

    counterState_t state;
    counterState_t stateNext;

    // Counter register; reset wins over any pending update.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= WEAK_NT;
        end else begin
            state <= stateNext;
        end
    end

    // Saturating step and prediction output.
    always_comb begin
        stateNext    = state;
        prediction_o = state[1];
        if (update_i) begin
            case (state)
                STRONG_NT: stateNext = taken_i ? WEAK_NT  : STRONG_NT;
                WEAK_NT:   stateNext = taken_i ? WEAK_T   : STRONG_NT;
                WEAK_T:    stateNext = taken_i ? STRONG_T : WEAK_NT;
                STRONG_T:  stateNext = taken_i ? STRONG_T : WEAK_T;
                default:   stateNext = state;
            endcase
`ifdef BRPRED_WRITE_BYPASS_EN
            // Bypass lives in the entry: update_i is only high for the written
            // index, so the read mux sees it only when read and write match.
            prediction_o = stateNext[1];
`endif
        end
    end
endmodule

// Enable-gated one-hot write decoder.
module decoder5x32 #(
    parameter int ADDR_W = 5
) (
    input  logic                     en_i,
    input  logic [ADDR_W-1:0]        addr_i,
    output logic [(2**ADDR_W)-1:0]   dec_o
);
    localparam int unsigned NUM_LINES = 2 ** ADDR_W;

    // Line i active only when enabled and the index matches; an X index with
    // the enable low still yields all zeros.
    always_comb begin
        dec_o = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            dec_o[i] = en_i && (addr_i == ADDR_W'(i));
        end
    end
endmodule

// Read-side selector of one entry's prediction.
module mux32x1 #(
    parameter int ADDR_W = 5
) (
    input  logic [(2**ADDR_W)-1:0] in_i,
    input  logic [ADDR_W-1:0]      sel_i,
    output logic                   out_o
);
    // Pick the prediction bit of the selected entry.
    always_comb begin
        out_o = in_i[sel_i];
    end
endmodule

module branch_predictor_table #(
    parameter int ADDR_W      = 5,
    parameter int NUM_ENTRIES = 2 ** ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    branch_predictor_table_if.slave  bp
);
    logic [NUM_ENTRIES-1:0] decoded;
    logic [NUM_ENTRIES-1:0] entryPred;

    decoder5x32 #(.ADDR_W(ADDR_W)) uDecoder (
        .en_i   (bp.anUpdate_i),
        .addr_i (bp.branchAddrWrite_i),
        .dec_o  (decoded)
    );

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : gEntry
        branchPredictionSM uEntry (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .update_i     (decoded[g]),
            .taken_i      (bp.brTaken_i),
            .prediction_o (entryPred[g])
        );
    end

    mux32x1 #(.ADDR_W(ADDR_W)) uReadMux (
        .in_i  (entryPred),
        .sel_i (bp.branchAddrRead_i),
        .out_o (bp.whatToDoBranch_o)
    );
endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench for branch_predictor_table: reset state, saturation at both
// ends, entry isolation, idle hold, read/write bypass and reset priority.
module tb_branch_predictor_table;
    logic clk;
    logic reset;
    int   total;
    int   bad;

`ifdef BRPRED_WRITE_BYPASS_EN
    localparam logic BYPASS_EXP = 1'b1;
`else
    localparam logic BYPASS_EXP = 1'b0;
`endif

    branch_predictor_table_if #(.ADDR_W(5)) bpIf ();

    branch_predictor_table #(.ADDR_W(5), .NUM_ENTRIES(32)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bp      (bpIf)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic exp);
        #1;
        total++;
        assert (bpIf.whatToDoBranch_o === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, bpIf.whatToDoBranch_o, exp);
        end
    endtask

    task automatic readAt(input logic [4:0] idx, input string tag, input logic exp);
        bpIf.branchAddrRead_i = idx;
        check(tag, exp);
    endtask

    // One updating edge, then drop the enable so the check sees the stored value.
    task automatic step(input logic taken);
        bpIf.anUpdate_i = 1'b1;
        bpIf.brTaken_i  = taken;
        tick();
        bpIf.anUpdate_i = 1'b0;
    endtask

    task automatic exercise(input logic [4:0] idx);
        bpIf.branchAddrRead_i  = idx;
        bpIf.branchAddrWrite_i = idx;
        step(1'b0); check($sformatf("nt1_idx%0d", idx), 1'b0);
        step(1'b0); check($sformatf("nt2_idx%0d", idx), 1'b0);
        step(1'b0); check($sformatf("nt3_idx%0d", idx), 1'b0);
        step(1'b1); check($sformatf("t1_idx%0d", idx), 1'b0);
        step(1'b1); check($sformatf("t2_idx%0d", idx), 1'b1);
        step(1'b1); check($sformatf("t3_idx%0d", idx), 1'b1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bpIf.anUpdate_i        = 1'b0;
        bpIf.brTaken_i         = 1'b0;
        bpIf.branchAddrWrite_i = 5'd0;
        bpIf.branchAddrRead_i  = 5'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state: every counter weak-not-taken.
        readAt(5'd0,  "rst_idx0",  1'b0);
        readAt(5'd4,  "rst_idx4",  1'b0);
        readAt(5'd15, "rst_idx15", 1'b0);
        readAt(5'd27, "rst_idx27", 1'b0);

        // Saturation low then high on several entries.
        exercise(5'd0);
        exercise(5'd4);
        exercise(5'd15);
        exercise(5'd27);
        readAt(5'd0, "isolate_idx0", 1'b1);

        // Update 23 while reading 6.
        bpIf.branchAddrRead_i  = 5'd6;
        bpIf.branchAddrWrite_i = 5'd23;
        for (int i = 0; i < 6; i++) begin
            step(i >= 3);
            check($sformatf("read6_step%0d", i), 1'b0);
        end
        readAt(5'd23, "after_idx23", 1'b1);

        // Idle: enable low, outcome toggling, write index unknown.
        bpIf.branchAddrWrite_i = 'x;
        for (int i = 0; i < 10; i++) begin
            bpIf.brTaken_i = i[0];
            tick();
        end
        readAt(5'd23, "idle_idx23", 1'b1);
        readAt(5'd6,  "idle_idx6",  1'b0);
        readAt(5'd0,  "idle_idx0",  1'b1);

        // Same-cycle read of the index being written (counter 9 at 01).
        bpIf.branchAddrRead_i  = 5'd9;
        bpIf.branchAddrWrite_i = 5'd9;
        bpIf.brTaken_i         = 1'b1;
        bpIf.anUpdate_i        = 1'b1;
        check("bypass_pre_edge", BYPASS_EXP);
        tick();
        bpIf.anUpdate_i = 1'b0;
        check("bypass_post_edge", 1'b1);

        // Reset with a pending update on a strong-taken entry.
        reset = 1'b1;
        bpIf.anUpdate_i        = 1'b1;
        bpIf.brTaken_i         = 1'b0;
        bpIf.branchAddrWrite_i = 5'd4;
        tick();
        reset = 1'b0;
        bpIf.anUpdate_i = 1'b0;
        readAt(5'd0,  "rst2_idx0",  1'b0);
        readAt(5'd4,  "rst2_idx4",  1'b0);
        readAt(5'd9,  "rst2_idx9",  1'b0);
        readAt(5'd23, "rst2_idx23", 1'b0);
        readAt(5'd27, "rst2_idx27", 1'b0);

        // One taken step from 01 must reach 10.
        bpIf.branchAddrRead_i  = 5'd4;
        bpIf.branchAddrWrite_i = 5'd4;
        step(1'b1);
        check("rst2_taken_idx4", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
